// File: rtl/seven_seg_scan_n.sv
// seven_seg_scan_n: N-digit time-multiplexed seven-segment driver with dead time,
// per-digit blanking and dp, leading-zero suppression and a frame-coherent input snapshot.
// Optional feature macro SEG_BRIGHTNESS_EN adds a 4-bit PWM brightness input.
module seven_seg_scan_n #(
  parameter int N_DIGITS       = 2,
  parameter int REFRESH_DIV    = 24000,
  parameter int BLANK_CYCLES   = 64,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic                  lz_en,
`ifdef SEG_BRIGHTNESS_EN
  input  logic [3:0]            brightness,
`endif
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic [IW-1:0]         digit_idx,
  output logic                  frame_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]       CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0]       CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0]       IDX_LAST  = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] AN_OFF    = (AN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [6:0]          SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                DP_OFF    = (SEG_ACTIVE_LOW != 0);

  typedef enum logic {BLANK, DRIVE} state_e;

  // With no dead time the slot starts straight in DRIVE; otherwise BLANK would
  // wait for a counter value that never comes.
  localparam state_e ST_RESET = (BLANK_CYCLES > 0) ? BLANK : DRIVE;

  // Standard hex glyphs, active-high, bit order gfedcba.
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0:    hex_glyph = 7'b0111111;
      4'h1:    hex_glyph = 7'b0000110;
      4'h2:    hex_glyph = 7'b1011011;
      4'h3:    hex_glyph = 7'b1001111;
      4'h4:    hex_glyph = 7'b1100110;
      4'h5:    hex_glyph = 7'b1101101;
      4'h6:    hex_glyph = 7'b1111101;
      4'h7:    hex_glyph = 7'b0000111;
      4'h8:    hex_glyph = 7'b1111111;
      4'h9:    hex_glyph = 7'b1101111;
      4'hA:    hex_glyph = 7'b1110111;
      4'hB:    hex_glyph = 7'b1111100;
      4'hC:    hex_glyph = 7'b0111001;
      4'hD:    hex_glyph = 7'b1011110;
      4'hE:    hex_glyph = 7'b1111001;
      default: hex_glyph = 7'b1110001;
    endcase
  endfunction

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  state_e                state_q, state_d;
  logic                  tick_q, tick_d;
  logic                  first_q;
  logic                  wrap, capture;

  logic [4*N_DIGITS-1:0] snap_dig_q;
  logic [N_DIGITS-1:0]   snap_dp_q, snap_blank_q;
  logic                  snap_lz_q;
`ifdef SEG_BRIGHTNESS_EN
  logic [3:0]            snap_bright_q;
  logic [3:0]            cur_bright;
`endif

  logic [4*N_DIGITS-1:0] cur_dig;
  logic [N_DIGITS-1:0]   cur_dp, cur_blank, lz_mask;
  logic                  cur_lz, above_zero, dark, pwm_on;
  logic [3:0]            dig_val;

  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  assign wrap    = (cnt_q == CNT_LAST);
  // Snapshot on the first cycle out of reset and at every frame boundary.
  assign capture = first_q | tick_d;

  // Next-state logic: slot counter, digit index, frame tick and BLANK/DRIVE phase.
  always_comb begin
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    tick_d  = 1'b0;
    state_d = state_q;
    if (wrap) begin
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      tick_d  = (idx_q == IDX_LAST);
      state_d = ST_RESET;
    end else if (state_q == BLANK && cnt_q == CNT_BLANK - 1'b1) begin
      state_d = DRIVE;
    end
  end

  // Scan state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      state_q <= ST_RESET;
      tick_q  <= 1'b0;
      first_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      tick_q  <= tick_d;
      first_q <= 1'b0;
    end
  end

  // Frame snapshot of every display input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_dig_q    <= '0;
      snap_dp_q     <= '0;
      snap_blank_q  <= '0;
      snap_lz_q     <= 1'b0;
`ifdef SEG_BRIGHTNESS_EN
      snap_bright_q <= '0;
`endif
    end else if (capture) begin
      snap_dig_q    <= digits;
      snap_dp_q     <= dp_in;
      snap_blank_q  <= blank_mask;
      snap_lz_q     <= lz_en;
`ifdef SEG_BRIGHTNESS_EN
      snap_bright_q <= brightness;
`endif
    end
  end

  // Decode of the current digit; on the very first cycle the snapshot is still
  // being loaded, so the live inputs stand in for it.
  always_comb begin
    cur_dig   = first_q ? digits     : snap_dig_q;
    cur_dp    = first_q ? dp_in      : snap_dp_q;
    cur_blank = first_q ? blank_mask : snap_blank_q;
    cur_lz    = first_q ? lz_en      : snap_lz_q;

    lz_mask    = '0;
    above_zero = cur_lz;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      above_zero = above_zero && (cur_dig[4*k +: 4] == 4'h0);
      lz_mask[k] = above_zero;
    end

    dig_val = cur_dig[{idx_q, 2'b00} +: 4];
    dark    = cur_blank[idx_q] | lz_mask[idx_q];

`ifdef SEG_BRIGHTNESS_EN
    cur_bright = first_q ? brightness : snap_bright_q;
    pwm_on     = (4'(cnt_q - CNT_BLANK) < cur_bright);
`else
    pwm_on     = 1'b1;
`endif

    an_d = AN_OFF;
    if (state_q == DRIVE && !dark && pwm_on)
      an_d = AN_OFF ^ (N_DIGITS'(1) << idx_q);

    // Segments and dp only load while the anodes are dark (cnt 0 covers the
    // zero-dead-time case, where both pins switch together).
    seg_d = seg_q;
    dp_d  = dp_q;
    if (state_q == BLANK || cnt_q == '0) begin
      seg_d = dark ? SEG_OFF : (hex_glyph(dig_val) ^ SEG_OFF);
      dp_d  = (!dark && cur_dp[idx_q]) ? ~DP_OFF : DP_OFF;
    end
  end

  // Registered pin drivers, forced inactive by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
      dp_q  <= DP_OFF;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_idx  = idx_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scan_n.sv
// Directed bench for seven_seg_scan_n: two instances (2 and 4 digits, 16-cycle
// slots, 2 dead-time cycles, active-low pins) stepped on a cycle count from reset release.
// Outputs are sampled on the falling edge.
module tb_seven_seg_scan_n;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0]  dig2;
  logic [1:0]  dpi2, bm2;
  logic        lz2;
  logic [6:0]  seg2;
  logic        dp2;
  logic [1:0]  an2;
  logic [0:0]  idx2;
  logic        ft2;

  logic [15:0] dig4;
  logic [3:0]  dpi4, bm4;
  logic        lz4;
  logic [6:0]  seg4;
  logic        dp4;
  logic [3:0]  an4;
  logic [1:0]  idx4;
  logic        ft4;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  seven_seg_scan_n #(
    .N_DIGITS(2), .REFRESH_DIV(16), .BLANK_CYCLES(2), .AN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) u2 (
    .clk(clk), .reset(reset), .digits(dig2), .dp_in(dpi2), .blank_mask(bm2), .lz_en(lz2),
`ifdef SEG_BRIGHTNESS_EN
    .brightness(4'd15),
`endif
    .seg(seg2), .dp(dp2), .an(an2), .digit_idx(idx2), .frame_tick(ft2)
  );

  seven_seg_scan_n #(
    .N_DIGITS(4), .REFRESH_DIV(16), .BLANK_CYCLES(2), .AN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) u4 (
    .clk(clk), .reset(reset), .digits(dig4), .dp_in(dpi4), .blank_mask(bm4), .lz_en(lz4),
`ifdef SEG_BRIGHTNESS_EN
    .brightness(4'd15),
`endif
    .seg(seg4), .dp(dp4), .an(an4), .digit_idx(idx4), .frame_tick(ft4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to the falling edge that follows the k-th rising edge since release.
  task automatic wait_to(input int k);
    while (cyc < k) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Active-low glyphs: 0=40 1=79 2=24 3=30 4=19 5=12 A=08
  initial begin
    reset = 1'b1;
    dig2 = 8'hA3;  dpi2 = 2'b00; bm2 = 2'b00; lz2 = 1'b0;
    dig4 = 16'h0050; dpi4 = 4'h0; bm4 = 4'h0; lz4 = 1'b1;

    #12;
    chk("rst_an",   32'(an2),  32'h3);
    chk("rst_seg",  32'(seg2), 32'h7F);
    chk("rst_dp",   32'(dp2),  32'h1);
    chk("rst_tick", 32'(ft2),  32'h0);
    chk("rst_idx",  32'(idx2), 32'h0);

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;

    // Frame 0: A3 on the 2-digit, 0050 with lz on the 4-digit.
    wait_to(1);  chk("dead_an_c1", 32'(an2), 32'h3);
    wait_to(2);  chk("dead_an_c2", 32'(an2), 32'h3);
    wait_to(3);  chk("drv_an_c3",  32'(an2), 32'h2);
    wait_to(8);
    chk("s0_an",   32'(an2),  32'h2);
    chk("s0_seg3", 32'(seg2), 32'h30);
    chk("s0_dp",   32'(dp2),  32'h1);
    chk("lz_d0_an",  32'(an4),  32'hE);
    chk("lz_d0_seg", 32'(seg4), 32'h40);
    wait_to(16); chk("tail_an_c0", 32'(an2), 32'h2);
    wait_to(17); chk("dead_an_s1", 32'(an2), 32'h3);
    wait_to(20);
    chk("s1_idx", 32'(idx2), 32'h1);
    dig2 = 8'h12;
    wait_to(24);
    chk("s1_an",   32'(an2),  32'h1);
    chk("s1_segA", 32'(seg2), 32'h08);
    chk("lz_d1_an",  32'(an4),  32'hD);
    chk("lz_d1_seg", 32'(seg4), 32'h12);
    wait_to(31); chk("tick_pre", 32'(ft2), 32'h0);
    wait_to(32);
    chk("tick_f0",   32'(ft2),  32'h1);
    chk("idx_wrap",  32'(idx2), 32'h0);
    chk("tick4_mid", 32'(ft4),  32'h0);
    wait_to(33); chk("tick_post", 32'(ft2), 32'h1 ^ 32'h1);

    // Frame 1: shows 12; new inputs arrive mid-frame and must wait.
    wait_to(36);
    dig2 = 8'h34; dpi2 = 2'b01; bm2 = 2'b10;
    dig4 = 16'h0000;
    wait_to(40);
    chk("snap_s0_seg2", 32'(seg2), 32'h24);
    chk("lz_d2_an",     32'(an4),  32'hF);
    wait_to(56);
    chk("snap_s1_seg1", 32'(seg2), 32'h79);
    chk("snap_s1_dp",   32'(dp2),  32'h1);
    chk("lz_d3_an",     32'(an4),  32'hF);
    wait_to(64); chk("tick4_f0", 32'(ft4), 32'h1);

    // Frame 2: 34 with digit 1 masked and dp on digit 0.
    wait_to(70);
    bm2 = 2'b00;
    wait_to(72);
    chk("mask_s0_an",  32'(an2),  32'h2);
    chk("mask_s0_seg", 32'(seg2), 32'h19);
    chk("mask_s0_dp",  32'(dp2),  32'h0);
    chk("zero_d0_an",  32'(an4),  32'hE);
    chk("zero_d0_seg", 32'(seg4), 32'h40);
    wait_to(81); chk("mask_dead",  32'(an2), 32'h3);
    wait_to(88);
    chk("mask_s1_an", 32'(an2), 32'h3);
    chk("mask_s1_dp", 32'(dp2), 32'h1);
    chk("zero_d1_an", 32'(an4), 32'hF);
    wait_to(96); chk("tick_f2", 32'(ft2), 32'h1);
    wait_to(104); chk("zero_d2_an", 32'(an4), 32'hF);

    // Frame 3: mask cleared; reset lands in the middle of digit 1's DRIVE.
    wait_to(120);
    chk("pre_rst_an",  32'(an2),  32'h1);
    chk("pre_rst_seg", 32'(seg2), 32'h30);
    chk("pre_rst_idx", 32'(idx2), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_an",   32'(an2),  32'h3);
    chk("mid_rst_seg",  32'(seg2), 32'h7F);
    chk("mid_rst_dp",   32'(dp2),  32'h1);
    chk("mid_rst_tick", 32'(ft2),  32'h0);
    chk("mid_rst_idx",  32'(idx2), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
    chk("rel_idx", 32'(idx2), 32'h0);
    wait_to(2);  chk("rel_dead_an", 32'(an2), 32'h3);
    wait_to(3);  chk("rel_drv_an",  32'(an2), 32'h2);
    wait_to(8);
    chk("rel_seg4", 32'(seg2), 32'h19);
    chk("rel_dp",   32'(dp2),  32'h0);
    wait_to(24);
    chk("rel_s1_an",  32'(an2),  32'h1);
    chk("rel_s1_seg", 32'(seg2), 32'h30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_n.md
Name: seven_seg_scan_n

Overview:
Parametrised N-digit time-multiplexed seven-segment driver. It is the successor to the fixed two-digit multiplexer. Features: generic digit count, configurable refresh rate, anti-ghosting dead time, per-digit blanking and decimal points, leading-zero suppression, and a frame-coherent input snapshot. It sits between the top-level datapath (switch or sum values) and the display pins.

Parameters:
N_DIGITS, 2, number of digits/anodes (>=1)
REFRESH_DIV, 24000, clk cycles per digit slot (must be > BLANK_CYCLES+1)
BLANK_CYCLES, 64, dead-time cycles at slot start with all anodes off
AN_ACTIVE_LOW, 1, 1 means anodes are driven low when on
SEG_ACTIVE_LOW, 1, 1 means segments and dp are driven low when lit

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
digits  in  4*N_DIGITS  hex values; digit i at [4i+3:4i]; digit N_DIGITS-1 is most significant
dp_in  in  N_DIGITS  decimal point request per digit
blank_mask  in  N_DIGITS  1 forces that digit dark
lz_en  in  1  leading-zero suppression enable
seg  out  7  segments; seg[0]=a … seg[6]=g
dp  out  1  decimal point
an  out  N_DIGITS  anode enables
digit_idx  out  max(1,$clog2(N_DIGITS))  digit currently being scanned
frame_tick  out  1  one-cycle pulse when idx wraps to 0

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, named reset. Reset sets:
  - slot counter = 0, idx = 0, state = BLANK
  - an, seg and dp all at their inactive level
  - frame_tick = 0, snapshot registers = 0
- Slot counter: counts 0..REFRESH_DIV-1 and wraps.
  - At wrap, idx advances by 1; idx wraps N_DIGITS-1 -> 0.
  - When idx goes to 0, frame_tick = 1 for exactly one cycle.
  - With N_DIGITS=1, idx stays 0 and frame_tick pulses every slot.
- FSM, two states:
  - BLANK: counter < BLANK_CYCLES. All anodes inactive.
  - DRIVE: counter >= BLANK_CYCLES. Only an[idx] is active, unless that digit is blanked.
  - DRIVE -> BLANK at slot wrap. BLANK -> DRIVE when counter == BLANK_CYCLES-1.
  - BLANK_CYCLES=0 makes BLANK never entered; this is legal.
- Snapshot: on the cycle idx becomes 0, and on the first cycle after reset release, the full digits, dp_in, blank_mask and lz_en are registered. All decode uses this snapshot, so input changes mid-frame never tear the displayed frame.
- Leading-zero suppression (lz_en=1): a digit k>0 is blanked if it and every digit above it are 0. Digit 0 is never suppressed, so value 00 shows "0" on digit 0 only.
- Blanking: a digit blanked by blank_mask or lz keeps its anode inactive for the whole slot. Its slot time is still consumed, so refresh duty stays constant.
- Decode: hex 0-F in standard glyphs (active-high pattern gfedcba):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
  - Inverted when SEG_ACTIVE_LOW=1.
- Output registers: seg, dp and an are registered. The slot counter/idx change becomes visible on the pins 1 cycle later. seg/dp change only during BLANK, never while an anode is on.
- Reset mid-scan: outputs go inactive immediately (async). After release, scanning restarts at idx 0 in BLANK.

Optional Feature:
SEG_BRIGHTNESS_EN
- Defined: adds port brightness in 4. During DRIVE, an[idx] is active only when the low 4 bits of (counter-BLANK_CYCLES) < brightness.
  - brightness 0 = dark; 15 = 15/16 duty.
  - brightness is sampled with the frame snapshot.
- Undefined: no brightness port; the anode is on for the full DRIVE phase.

Test Plan:
- Reset: assert reset asynchronously mid-DRIVE with N=2, active-low polarities -> same cycle an=2'b11, seg=7'h7F, dp=1, frame_tick=0; after release, digit_idx=0.
- Decode and scan: N=2, REFRESH_DIV=16, BLANK_CYCLES=2, digits=8'hA3.
  - Slot 0 (DRIVE): an=2'b10, seg=~7'b1001111 (3).
  - Slot 1: an=2'b01, seg=~7'b1110111 (A).
  - Anodes stay 2'b11 for 2 cycles at each slot start; frame_tick pulses every 32 cycles.
- Leading zero: N=4, digits=16'h0050, lz_en=1 -> digits 3 and 2 stay dark, digits 1 and 0 show 5 and 0. digits=16'h0000 -> only digit 0 lit, showing "0".
- Snapshot coherence: change digits from 8'h12 to 8'h34 while idx=0 -> the frame shows 2 then 1; the next frame shows 4 then 3; never a mixed 2/3 frame.
- Mask and dp: blank_mask=2'b10, dp_in=2'b01 -> digit 1's anode never active; dp lit only during digit 0's DRIVE; slot timing unchanged.
- Brightness (SEG_BRIGHTNESS_EN): brightness=4, REFRESH_DIV=34, BLANK_CYCLES=2 -> 8 active anode cycles per slot (two 16-cycle windows, 4 each). brightness=0 -> anode never active.
